sound_comm_port: RTL and testbench

Mailbox between the 68010 main CPU and the 6502 I/O-sound CPU. It is the upstream feeder of io_sound and drives SDin68k, SNDNMI_b, ctrl_SNDBUF and ctrl_68kBUF. It consumes SDout68k, WR68k_b and RD68k_b from io_sound. The block holds one byte in each direction with full flags, NMIs the 6502 on each 68k write, and interrupts the 68k on each 6502 write.

---
 rtl/sound_comm_port.sv | 143 ++++++++++++++
 tb/tb_sound_comm_port.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_comm_port.sv
// Mailbox between the 68010 main CPU and the 6502 sound CPU. It holds one byte in each
// direction with full/overrun flags, sends an NMI pulse to the 6502 and an IRQ to the 68k.
module sound_comm_port #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NMI_WIDTH   = 16,
    parameter bit          IRQ_EN      = 1'b1
) (
    input  logic       clk100,
    input  logic       SNDRST_b,
    input  logic       WRsnd_b,
    input  logic       RDsnd_b,
    input  logic [7:0] D68kin,
    output logic [7:0] D68kout,
    output logic       SNDIRQ68k_b,
    output logic [7:0] SDin68k,
    input  logic [7:0] SDout68k,
    input  logic       WR68k_b,
    input  logic       RD68k_b,
    output logic       SNDNMI_b,
    output logic       ctrl_SNDBUF,
    output logic       ctrl_68kBUF,
    output logic       ovr_snd,
    output logic       ovr_68k
);

    localparam int unsigned LAST   = SYNC_STAGES - 1;
    localparam int unsigned WR_SND = 0;
    localparam int unsigned RD_SND = 1;
    localparam int unsigned WR_68K = 2;
    localparam int unsigned RD_68K = 3;
    localparam logic [7:0]  NMI_LOAD = 8'(NMI_WIDTH);

    logic [3:0]           stb_sync   [SYNC_STAGES];
    logic [7:0]           d68k_sync  [SYNC_STAGES];
    logic [7:0]           sdout_sync [SYNC_STAGES];
    logic [3:0]           stb_dly;
    logic [3:0]           fall;
    logic [3:0]           evt_q;
    logic [SYNC_STAGES:0] warm;
    logic                 armed;
    logic [7:0]           snd_data_q;
    logic [7:0]           cpu_data_q;
    logic [7:0]           nmi_cnt;
    logic [7:0]           nmi_cnt_next;

    // Strobes reset high and data low, so a fresh chain never presents a falling edge by itself.
    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stb_sync[i]   <= '1;
                d68k_sync[i]  <= '0;
                sdout_sync[i] <= '0;
            end
            stb_dly <= '1;
        end else begin
            stb_sync[0]   <= {RD68k_b, WR68k_b, RDsnd_b, WRsnd_b};
            d68k_sync[0]  <= D68kin;
            sdout_sync[0] <= SDout68k;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stb_sync[i]   <= stb_sync[i-1];
                d68k_sync[i]  <= d68k_sync[i-1];
                sdout_sync[i] <= sdout_sync[i-1];
            end
            stb_dly <= stb_sync[LAST];
        end
    end

    assign fall  = ~stb_sync[LAST] & stb_dly;
    assign armed = warm[SYNC_STAGES];

    // A strobe already low at reset release shows up as a falling edge once the chain refills;
    // edges are ignored until every stage holds a post-reset sample.
    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            warm       <= '0;
            evt_q      <= '0;
            snd_data_q <= '0;
            cpu_data_q <= '0;
        end else begin
            warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
            evt_q <= armed ? fall : '0;
            if (fall[WR_SND]) snd_data_q <= d68k_sync[LAST];
            if (fall[WR_68K]) cpu_data_q <= sdout_sync[LAST];
        end
    end

    always_comb begin
        nmi_cnt_next = nmi_cnt;
        if (evt_q[WR_SND]) begin
            nmi_cnt_next = NMI_LOAD;
        end else if (nmi_cnt != '0) begin
            nmi_cnt_next = nmi_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            nmi_cnt  <= '0;
            SNDNMI_b <= 1'b1;
        end else begin
            nmi_cnt  <= nmi_cnt_next;
            SNDNMI_b <= (nmi_cnt_next == '0);
        end
    end

    // A write landing on the same edge as the read wins and is not an overrun.
    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            SDin68k     <= '0;
            ctrl_SNDBUF <= 1'b0;
            ovr_snd     <= 1'b0;
        end else if (evt_q[WR_SND]) begin
            SDin68k     <= snd_data_q;
            ctrl_SNDBUF <= 1'b1;
            ovr_snd     <= ovr_snd | (ctrl_SNDBUF & ~evt_q[RD_68K]);
        end else if (evt_q[RD_68K]) begin
            ctrl_SNDBUF <= 1'b0;
        end
    end

    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            D68kout     <= '0;
            ctrl_68kBUF <= 1'b0;
            ovr_68k     <= 1'b0;
        end else if (evt_q[WR_68K]) begin
            D68kout     <= cpu_data_q;
            ctrl_68kBUF <= 1'b1;
            ovr_68k     <= ovr_68k | (ctrl_68kBUF & ~evt_q[RD_SND]);
        end else if (evt_q[RD_SND]) begin
            ctrl_68kBUF <= 1'b0;
        end
    end

    always_ff @(posedge clk100 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            SNDIRQ68k_b <= 1'b1;
        end else begin
            SNDIRQ68k_b <= ~(ctrl_68kBUF & IRQ_EN);
        end
    end

endmodule

// File: tb/tb_sound_comm_port.sv
// Scoreboard bench for sound_comm_port: directed mailbox traffic queues timed expectations,
// and independent monitors compare them and every NMI pulse length as the DUT produces them.
module tb_sound_comm_port;

    localparam int SYNC  = 2;
    localparam int NMI_W = 16;
    localparam int LAT   = SYNC + 1;

    typedef enum int {SIG_SDIN, SIG_DOUT, SIG_SNDBUF, SIG_68KBUF,
                      SIG_OVRS, SIG_OVR68, SIG_NMI, SIG_IRQ} sig_e;
    typedef enum int {P_WRSND, P_RDSND, P_WR68K, P_RD68K} stb_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk100 = 1'b0;
    logic       SNDRST_b;
    logic       WRsnd_b, RDsnd_b, WR68k_b, RD68k_b;
    logic [7:0] D68kin, SDout68k;
    logic [7:0] D68kout, SDin68k;
    logic       SNDIRQ68k_b, SNDNMI_b, ctrl_SNDBUF, ctrl_68kBUF, ovr_snd, ovr_68k;

    exp_t exp_q[$];
    int   nmi_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   nmi_low = 0;

    sound_comm_port #(
        .SYNC_STAGES(SYNC),
        .NMI_WIDTH  (NMI_W),
        .IRQ_EN     (1'b1)
    ) dut (
        .clk100     (clk100),
        .SNDRST_b   (SNDRST_b),
        .WRsnd_b    (WRsnd_b),
        .RDsnd_b    (RDsnd_b),
        .D68kin     (D68kin),
        .D68kout    (D68kout),
        .SNDIRQ68k_b(SNDIRQ68k_b),
        .SDin68k    (SDin68k),
        .SDout68k   (SDout68k),
        .WR68k_b    (WR68k_b),
        .RD68k_b    (RD68k_b),
        .SNDNMI_b   (SNDNMI_b),
        .ctrl_SNDBUF(ctrl_SNDBUF),
        .ctrl_68kBUF(ctrl_68kBUF),
        .ovr_snd    (ovr_snd),
        .ovr_68k    (ovr_68k)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    function automatic logic [7:0] observe(input sig_e s);
        case (s)
            SIG_SDIN:   return SDin68k;
            SIG_DOUT:   return D68kout;
            SIG_SNDBUF: return {7'd0, ctrl_SNDBUF};
            SIG_68KBUF: return {7'd0, ctrl_68kBUF};
            SIG_OVRS:   return {7'd0, ovr_snd};
            SIG_OVR68:  return {7'd0, ovr_68k};
            SIG_NMI:    return {7'd0, SNDNMI_b};
            default:    return {7'd0, SNDIRQ68k_b};
        endcase
    endfunction

    // Timed-expectation monitor: compares everything due at this cycle.
    always @(negedge clk100) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                checks++;
                if (observe(exp_q[i].sig) !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%02h required=%02h",
                             exp_q[i].name, cyc, observe(exp_q[i].sig), exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s cyc=%0d actual=unsampled required=%02h",
                         exp_q[i].name, exp_q[i].cyc, exp_q[i].val);
                exp_q.delete(i);
            end
        end
    end

    // NMI monitor: each completed low pulse must match the next expected length.
    always @(negedge clk100) begin
        if (SNDNMI_b === 1'b0) begin
            nmi_low++;
        end else if (nmi_low != 0) begin
            checks++;
            if (nmi_q.size() == 0) begin
                errors++;
                $display("FAIL nmi_unexpected cyc=%0d actual=%0d required=none", cyc, nmi_low);
            end else begin
                int want;
                want = nmi_q.pop_front();
                if (want != nmi_low) begin
                    errors++;
                    $display("FAIL nmi_len cyc=%0d actual=%0d required=%0d", cyc, nmi_low, want);
                end
            end
            nmi_low = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk100);
    endtask

    task automatic expect_at(input int c, input sig_e s, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic set_stb(input stb_e which, input logic lvl);
        case (which)
            P_WRSND: WRsnd_b = lvl;
            P_RDSND: RDsnd_b = lvl;
            P_WR68K: WR68k_b = lvl;
            default: RD68k_b = lvl;
        endcase
    endtask

    task automatic pulse(input stb_e which, input int low, input int high);
        set_stb(which, 1'b0);
        tick(low);
        set_stb(which, 1'b1);
        tick(high);
    endtask

    initial begin
        int t0;
        SNDRST_b = 1'b0;
        WRsnd_b  = 1'b1;
        RDsnd_b  = 1'b1;
        WR68k_b  = 1'b1;
        RD68k_b  = 1'b1;
        D68kin   = 8'h00;
        SDout68k = 8'h00;
        tick(3);
        #2 SNDRST_b = 1'b1;
        tick(1);

        t0 = cyc + 1;
        expect_at(t0, SIG_SDIN,   8'h00, "rst_sdin");
        expect_at(t0, SIG_DOUT,   8'h00, "rst_dout");
        expect_at(t0, SIG_SNDBUF, 8'h00, "rst_sndbuf");
        expect_at(t0, SIG_68KBUF, 8'h00, "rst_68kbuf");
        expect_at(t0, SIG_OVRS,   8'h00, "rst_ovr_snd");
        expect_at(t0, SIG_OVR68,  8'h00, "rst_ovr_68k");
        expect_at(t0, SIG_NMI,    8'h01, "rst_nmi");
        expect_at(t0, SIG_IRQ,    8'h01, "rst_irq");
        tick(LAT + 3);

        // 68k write A5, then 6502 read
        D68kin = 8'hA5;
        t0 = cyc + 1;
        expect_at(t0 + LAT - 1,     SIG_SNDBUF, 8'h00, "wr_snd_not_early");
        expect_at(t0 + LAT,         SIG_SDIN,   8'hA5, "wr_snd_data");
        expect_at(t0 + LAT,         SIG_SNDBUF, 8'h01, "wr_snd_flag");
        expect_at(t0 + LAT,         SIG_NMI,    8'h00, "wr_snd_nmi_low");
        expect_at(t0 + LAT + NMI_W, SIG_NMI,    8'h01, "wr_snd_nmi_end");
        nmi_q.push_back(NMI_W);
        pulse(P_WRSND, 6, 20);

        t0 = cyc + 1;
        expect_at(t0 + LAT - 1, SIG_SNDBUF, 8'h01, "rd_snd_not_early");
        expect_at(t0 + LAT,     SIG_SNDBUF, 8'h00, "rd_snd_clear");
        expect_at(t0 + LAT,     SIG_SDIN,   8'hA5, "rd_snd_hold");
        pulse(P_RD68K, 4, 6);

        // 6502 write 3C, then 68k read
        SDout68k = 8'h3C;
        t0 = cyc + 1;
        expect_at(t0 + LAT,     SIG_DOUT,   8'h3C, "wr_68k_data");
        expect_at(t0 + LAT,     SIG_68KBUF, 8'h01, "wr_68k_flag");
        expect_at(t0 + LAT,     SIG_IRQ,    8'h01, "wr_68k_irq_lag");
        expect_at(t0 + LAT + 1, SIG_IRQ,    8'h00, "wr_68k_irq");
        pulse(P_WR68K, 4, 6);

        t0 = cyc + 1;
        expect_at(t0 + LAT,     SIG_68KBUF, 8'h00, "rd_68k_clear");
        expect_at(t0 + LAT,     SIG_IRQ,    8'h00, "rd_68k_irq_lag");
        expect_at(t0 + LAT + 1, SIG_IRQ,    8'h01, "rd_68k_irq_off");
        expect_at(t0 + LAT + 1, SIG_DOUT,   8'h3C, "rd_68k_hold");
        pulse(P_RDSND, 4, 6);

        // 6502 side: simultaneous read/write, then an overrun
        SDout68k = 8'h81;
        pulse(P_WR68K, 4, 6);
        SDout68k = 8'h9E;
        t0 = cyc + 1;
        expect_at(t0 + LAT,     SIG_DOUT,   8'h9E, "sim68k_data");
        expect_at(t0 + LAT,     SIG_68KBUF, 8'h01, "sim68k_flag");
        expect_at(t0 + LAT,     SIG_OVR68,  8'h00, "sim68k_no_ovr");
        expect_at(t0 + LAT + 1, SIG_IRQ,    8'h00, "sim68k_irq");
        RDsnd_b = 1'b0;
        WR68k_b = 1'b0;
        tick(4);
        RDsnd_b = 1'b1;
        WR68k_b = 1'b1;
        tick(6);

        SDout68k = 8'hC3;
        t0 = cyc + 1;
        expect_at(t0 + LAT - 1, SIG_OVR68, 8'h00, "ovr68k_not_early");
        expect_at(t0 + LAT,     SIG_OVR68, 8'h01, "ovr68k_set");
        expect_at(t0 + LAT,     SIG_DOUT,  8'hC3, "ovr68k_data");
        pulse(P_WR68K, 4, 6);

        // 68k side: two writes 5 cycles apart without a read
        D68kin = 8'h11;
        t0 = cyc + 1;
        expect_at(t0 + LAT,             SIG_SDIN,   8'h11, "ovr_first_data");
        expect_at(t0 + LAT + 4,         SIG_OVRS,   8'h00, "ovr_not_early");
        expect_at(t0 + LAT + 5,         SIG_SDIN,   8'h22, "ovr_second_data");
        expect_at(t0 + LAT + 5,         SIG_OVRS,   8'h01, "ovr_snd_set");
        expect_at(t0 + LAT + 5,         SIG_SNDBUF, 8'h01, "ovr_flag");
        expect_at(t0 + LAT + 4 + NMI_W, SIG_NMI,    8'h00, "ovr_nmi_extended");
        expect_at(t0 + LAT + 5 + NMI_W, SIG_NMI,    8'h01, "ovr_nmi_end");
        nmi_q.push_back(5 + NMI_W);
        pulse(P_WRSND, 3, 2);
        D68kin = 8'h22;
        pulse(P_WRSND, 4, 25);

        t0 = cyc + 1;
        expect_at(t0 + LAT,     SIG_SNDBUF, 8'h00, "sticky_clear");
        expect_at(t0 + LAT + 1, SIG_OVRS,   8'h01, "sticky_ovr_snd");
        pulse(P_RD68K, 4, 6);

        // Reset while an NMI pulse runs and WRsnd_b stays low
        D68kin  = 8'h5A;
        WRsnd_b = 1'b0;
        t0 = cyc + 1;
        expect_at(t0 + LAT, SIG_SDIN, 8'h5A, "rstmid_data");
        nmi_q.push_back(4);
        while (cyc < t0 + LAT + 3) tick(1);
        #2 SNDRST_b = 1'b0;
        expect_at(cyc + 1, SIG_NMI,    8'h01, "rstmid_nmi");
        expect_at(cyc + 1, SIG_SNDBUF, 8'h00, "rstmid_sndbuf");
        expect_at(cyc + 1, SIG_OVRS,   8'h00, "rstmid_ovr_snd");
        expect_at(cyc + 1, SIG_OVR68,  8'h00, "rstmid_ovr_68k");
        tick(2);
        #2 SNDRST_b = 1'b1;
        expect_at(cyc + 8, SIG_SNDBUF, 8'h00, "rstmid_no_event");
        expect_at(cyc + 8, SIG_SDIN,   8'h00, "rstmid_no_data");
        expect_at(cyc + 8, SIG_NMI,    8'h01, "rstmid_no_nmi");
        tick(12);
        WRsnd_b = 1'b1;
        tick(6);

        // 68k side: read and write detected on the same edge
        D68kin = 8'h44;
        nmi_q.push_back(NMI_W);
        pulse(P_WRSND, 4, 20);
        D68kin = 8'h77;
        t0 = cyc + 1;
        expect_at(t0 + LAT,     SIG_SDIN,   8'h77, "simsnd_data");
        expect_at(t0 + LAT,     SIG_SNDBUF, 8'h01, "simsnd_flag");
        expect_at(t0 + LAT,     SIG_OVRS,   8'h00, "simsnd_no_ovr");
        expect_at(t0 + LAT + 1, SIG_SNDBUF, 8'h01, "simsnd_flag_hold");
        nmi_q.push_back(NMI_W);
        RD68k_b = 1'b0;
        WRsnd_b = 1'b0;
        tick(4);
        RD68k_b = 1'b1;
        WRsnd_b = 1'b1;
        tick(25);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
        end
        checks++;
        if (nmi_q.size() != 0) begin
            errors++;
            $display("FAIL missing_nmi_pulses actual=%0d required=0", nmi_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
